// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low polarity, the blank pattern and the hex glyph table.
// Segment vectors are ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic SEG_ON  = 1'b0;
    localparam logic SEG_OFF = 1'b1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        seg = SEG_BLANK;
        unique case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0011000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder with a forced-blank input.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            o_seg = hex_to_seg(i_nibble);
        end
    end

endmodule

// File: rtl/seg7_scan_display.sv
// N-digit hex 7-segment controller: shadow registers, leading-zero suppression, blinking,
// registered parallel outputs and a scanned segment/anode pair.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_blink_mask,
    input  logic [NUM_DIGITS-1:0]   i_dp_mask,
    input  logic                    i_lzs_en,
    output logic [7*NUM_DIGITS-1:0] o_hex,
    output logic [NUM_DIGITS-1:0]   o_dp,
    output logic [6:0]              o_mux_seg,
    output logic                    o_mux_dp,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic                    o_frame
);

    localparam int unsigned REF_W = $clog2(REFRESH_DIV);
    localparam int unsigned BLK_W = $clog2(BLINK_DIV);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_blink_mask;
    logic [NUM_DIGITS-1:0]   r_dp_mask;

    logic [REF_W-1:0]        r_refresh_cnt;
    logic [BLK_W-1:0]        r_blink_cnt;
    logic                    r_blink_phase;
    logic [IDX_W-1:0]        r_scan_idx;
    logic                    r_frame_pend;

    logic [7*NUM_DIGITS-1:0] r_hex;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [6:0]              r_mux_seg;
    logic                    r_mux_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame;

    logic                    w_refresh_wrap;
    logic                    w_blink_wrap;
    logic                    w_idx_wrap;
    logic [NUM_DIGITS-1:0]   w_lzs_blank;
    logic [NUM_DIGITS-1:0]   w_blink_blank;
    logic [NUM_DIGITS-1:0]   w_digit_blank;
    logic [NUM_DIGITS-1:0]   w_dp;
    logic [7*NUM_DIGITS-1:0] w_hex;
    logic [6:0]              w_mux_seg;
    logic                    w_mux_dp;
    logic [NUM_DIGITS-1:0]   w_an;

    assign w_refresh_wrap = (r_refresh_cnt == REF_MAX);
    assign w_blink_wrap   = (r_blink_cnt == BLK_MAX);
    assign w_idx_wrap     = w_refresh_wrap && (r_scan_idx == IDX_MAX);

    // Shadow registers and free-running counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_value       <= '0;
            r_blink_mask  <= '0;
            r_dp_mask     <= '0;
            r_refresh_cnt <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_scan_idx    <= '0;
            r_frame_pend  <= 1'b0;
        end else begin
            if (i_load) begin
                r_value      <= i_value;
                r_blink_mask <= i_blink_mask;
                r_dp_mask    <= i_dp_mask;
            end
            r_refresh_cnt <= w_refresh_wrap ? '0 : r_refresh_cnt + REF_W'(1);
            r_blink_cnt   <= w_blink_wrap ? '0 : r_blink_cnt + BLK_W'(1);
            if (w_blink_wrap) begin
                r_blink_phase <= ~r_blink_phase;
            end
            if (w_refresh_wrap) begin
                r_scan_idx <= w_idx_wrap ? '0 : r_scan_idx + IDX_W'(1);
            end
            // Delays the frame marker so it lines up with the registered anode for digit 0.
            r_frame_pend <= w_idx_wrap;
        end
    end

    // A digit is suppressed when it and every more-significant nibble are zero.
    always_comb begin
        logic zero_above;
        zero_above  = 1'b1;
        w_lzs_blank = '0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            zero_above     = zero_above & (r_value[4*k +: 4] == 4'h0);
            w_lzs_blank[k] = i_lzs_en & zero_above & (k != 0);
        end
    end

    assign w_blink_blank = r_blink_mask & {NUM_DIGITS{r_blink_phase}};
    assign w_digit_blank = w_lzs_blank | w_blink_blank;
    assign w_dp          = ~(r_dp_mask & ~w_blink_blank);

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        seg7_hex_decode u_decode (
            .i_nibble (r_value[4*k +: 4]),
            .i_blank  (w_digit_blank[k]),
            .o_seg    (w_hex[7*k +: 7])
        );
    end

    always_comb begin
        w_mux_seg = SEG_BLANK;
        w_mux_dp  = SEG_OFF;
        w_an      = '1;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (r_scan_idx == IDX_W'(k)) begin
                w_mux_seg = w_hex[7*k +: 7];
                w_mux_dp  = w_dp[k];
                w_an[k]   = SEG_ON;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hex     <= {NUM_DIGITS{SEG_BLANK}};
            r_dp      <= '1;
            r_mux_seg <= SEG_BLANK;
            r_mux_dp  <= SEG_OFF;
            r_an      <= '1;
            r_frame   <= 1'b0;
        end else begin
            r_hex     <= w_hex;
            r_dp      <= w_dp;
            r_mux_seg <= w_mux_seg;
            r_mux_dp  <= w_mux_dp;
            r_an      <= w_an;
            r_frame   <= r_frame_pend;
        end
    end

    assign o_hex     = r_hex;
    assign o_dp      = r_dp;
    assign o_mux_seg = r_mux_seg;
    assign o_mux_dp  = r_mux_dp;
    assign o_an      = r_an;
    assign o_frame   = r_frame;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench: a cycle model pushes expected outputs per clock edge into a scoreboard,
// popped and compared just after the edge, plus directed checks from the test plan.
module tb_seg7_scan_display;

    localparam int unsigned ND = 4;
    localparam int unsigned RD = 4;
    localparam int unsigned BD = 8;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] BLANK = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  blink_mask;
    logic [3:0]  dp_mask;
    logic        lzs_en;
    logic [27:0] hex;
    logic [3:0]  dp;
    logic [6:0]  mux_seg;
    logic        mux_dp;
    logic [3:0]  an;
    logic        frame;

    always #5 clk = ~clk;

    seg7_scan_display #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLINK_DIV   (BD)
    ) u_dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_load       (load),
        .i_value      (value),
        .i_blink_mask (blink_mask),
        .i_dp_mask    (dp_mask),
        .i_lzs_en     (lzs_en),
        .o_hex        (hex),
        .o_dp         (dp),
        .o_mux_seg    (mux_seg),
        .o_mux_dp     (mux_dp),
        .o_an         (an),
        .o_frame      (frame)
    );

    typedef struct packed {
        logic [27:0] hex;
        logic [3:0]  dp;
        logic [6:0]  mseg;
        logic        mdp;
        logic [3:0]  an;
        logic        frame;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [15:0] m_value = '0;
    logic [3:0]  m_blink = '0;
    logic [3:0]  m_dpm   = '0;
    int          m_ref   = 0;
    int          m_bc    = 0;
    int          m_idx   = 0;
    bit          m_phase = 1'b0;
    bit          m_frame_pend = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    // Expected outputs after this edge, from model state before it; then advance the model.
    task automatic model_edge();
        exp_t       e;
        logic [6:0] seg [4];
        logic [3:0] dpv;
        logic [3:0] nib;
        bit         zero_above;
        bit         bb;
        bit         lz;
        if (rst) begin
            e.hex = {4{BLANK}};
            e.dp = 4'hF;
            e.mseg = BLANK;
            e.mdp = 1'b1;
            e.an = 4'hF;
            e.frame = 1'b0;
            m_value = '0;
            m_blink = '0;
            m_dpm = '0;
            m_ref = 0;
            m_bc = 0;
            m_idx = 0;
            m_phase = 1'b0;
            m_frame_pend = 1'b0;
        end else begin
            zero_above = 1'b1;
            for (int k = 3; k >= 0; k--) begin
                nib = m_value[4*k +: 4];
                zero_above = zero_above && (nib == 4'h0);
                bb = m_phase && m_blink[k];
                lz = lzs_en && zero_above && (k > 0);
                seg[k] = (bb || lz) ? BLANK : SEG_TBL[nib];
                dpv[k] = !(m_dpm[k] && !bb);
            end
            e.hex = {seg[3], seg[2], seg[1], seg[0]};
            e.dp = dpv;
            e.mseg = seg[m_idx];
            e.mdp = dpv[m_idx];
            e.an = ~(4'b0001 << m_idx);
            e.frame = m_frame_pend;
            if (load) begin
                m_value = value;
                m_blink = blink_mask;
                m_dpm = dp_mask;
            end
            m_frame_pend = 1'b0;
            if (m_ref == RD - 1) begin
                m_ref = 0;
                m_frame_pend = (m_idx == ND - 1);
                m_idx = (m_idx + 1) % ND;
            end else begin
                m_ref++;
            end
            if (m_bc == BD - 1) begin
                m_bc = 0;
                m_phase = !m_phase;
            end else begin
                m_bc++;
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic check_outputs();
        exp_t e;
        check_val("sb_depth", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val("hex", hex, e.hex);
            check_val("dp", dp, e.dp);
            check_val("mux_seg", mux_seg, e.mseg);
            check_val("mux_dp", mux_dp, e.mdp);
            check_val("an", an, e.an);
            check_val("frame", frame, e.frame);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    initial begin
        int cnt;
        int cnt0;
        int guard;
        rst = 1'b1;
        load = 1'b0;
        value = '0;
        blink_mask = '0;
        dp_mask = '0;
        lzs_en = 1'b0;

        // Reset, with a load attempt that must be ignored.
        load = 1'b1;
        value = 16'h5A5A;
        repeat (3) step();
        check_val("rst_hex", hex, {4{BLANK}});
        check_val("rst_an", an, 4'hF);

        // Basic load, visible two edges after the load edge.
        rst = 1'b0;
        value = 16'h12AF;
        step();
        load = 1'b0;
        step();
        check_val("hex_12AF", hex, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110});

        cnt = 0;
        repeat (32) begin
            step();
            cnt += int'(frame);
        end
        check_val("frame_count", cnt, 2);

        // Leading-zero suppression.
        lzs_en = 1'b1;
        value = 16'h0007;
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        check_val("lzs_0007", hex, {BLANK, BLANK, BLANK, 7'b1111000});
        lzs_en = 1'b0;
        step();
        check_val("nolzs_0007", hex, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000});
        lzs_en = 1'b1;
        value = 16'h0000;
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        check_val("lzs_0000", hex, {BLANK, BLANK, BLANK, 7'b1000000});
        repeat (8) step();

        // Blink on digit 1 only.
        lzs_en = 1'b0;
        value = 16'h12AF;
        blink_mask = 4'b0010;
        load = 1'b1;
        step();
        load = 1'b0;
        blink_mask = 4'b0000;
        step();
        cnt = 0;
        cnt0 = 0;
        repeat (32) begin
            step();
            if (hex[13:7] == BLANK) cnt++;
            if (hex[6:0] == BLANK) cnt0++;
        end
        check_val("blink_d1_half", cnt, 16);
        check_val("blink_d0_steady", cnt0, 0);

        // Decimal point on a suppressed digit.
        lzs_en = 1'b1;
        value = 16'h0007;
        dp_mask = 4'b0100;
        load = 1'b1;
        step();
        load = 1'b0;
        dp_mask = 4'b0000;
        step();
        check_val("dp_suppr", dp, 4'b1011);
        check_val("seg_d2_blank", hex[20:14], BLANK);

        // Reset mid-scan while digit 2 is selected.
        guard = 0;
        while (an !== 4'b1011 && guard < 20) begin
            step();
            guard++;
        end
        check_val("an_reach_d2", an, 4'b1011);
        rst = 1'b1;
        step();
        check_val("an_rst_mid", an, 4'b1111);
        rst = 1'b0;
        step();
        check_val("an_restart", an, 4'b1110);
        repeat (6) step();

        // Load and reset in the same cycle.
        lzs_en = 1'b0;
        value = 16'hFFFF;
        dp_mask = 4'b1111;
        load = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        load = 1'b0;
        dp_mask = 4'b0000;
        step();
        check_val("load_vs_rst_hex", hex, {4{7'b1000000}});
        check_val("load_vs_rst_dp", dp, 4'hF);

        // Back-to-back loads: last write wins.
        value = 16'h1111;
        load = 1'b1;
        step();
        value = 16'h2222;
        step();
        load = 1'b0;
        step();
        check_val("b2b_hex", hex, {4{7'b0100100}});
        repeat (20) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
